palt_nios_sysid_checker: RTL and testbench

Avalon-MM read master that reads the two words of the system ID slave (ID at address 0, timestamp at address 1) and compares them with expected values. It sits alongside the Nios system ID peripheral and gives boot/diagnostic logic a hardware pass/fail for "bitstream matches software build" without involving the CPU. It runs one check after reset, or on request, and holds the result until the next check starts.

---
 rtl/palt_nios_sysid_checker.sv | 129 ++++++++++++
 tb/tb_palt_nios_sysid_checker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/palt_nios_sysid_checker.sv
// palt_nios_sysid_checker: reads sysid words 0/1 over Avalon-MM and flags mismatches.
// Define SYSID_CHECKER_TIMEOUT_EN to add a per-read waitrequest watchdog.
module palt_nios_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd8,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1649580841,
    parameter bit          AUTO_START         = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] read_id,
    output logic [31:0] read_ts
);
    typedef enum logic [2:0] {IDLE, ARM, RD_ID, RD_TS, DONE} state_t;

    state_t      state_q;
    logic        addr_q, rd_q, busy_q, done_q, pass_q, idm_q, tsm_q;
    logic [31:0] id_q, ts_q;

`ifdef SYSID_CHECKER_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        to_q;
    assign timeout = to_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign avm_address = addr_q;
    assign avm_read    = rd_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_mismatch = idm_q;
    assign ts_mismatch = tsm_q;
    assign read_id     = id_q;
    assign read_ts     = ts_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= AUTO_START ? ARM : IDLE;
            addr_q  <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            idm_q   <= 1'b0;
            tsm_q   <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
`ifdef SYSID_CHECKER_TIMEOUT_EN
            // stalls within one read are always consecutive, so any non-stall cycle rearms the count
            cnt_q <= '0;
`endif
            case (state_q)
                ARM: begin
                    state_q <= RD_ID;
                    rd_q    <= 1'b1;
                    busy_q  <= 1'b1;
                end
                IDLE, DONE: if (start) begin
                    state_q <= RD_ID;
                    addr_q  <= 1'b0;
                    rd_q    <= 1'b1;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                    idm_q   <= 1'b0;
                    tsm_q   <= 1'b0;
                    id_q    <= '0;
                    ts_q    <= '0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
                    to_q    <= 1'b0;
`endif
                end
                RD_ID, RD_TS: begin
                    if (!avm_waitrequest) begin
                        if (state_q == RD_ID) begin
                            state_q <= RD_TS;
                            addr_q  <= 1'b1;
                            id_q    <= avm_readdata;
                            idm_q   <= avm_readdata != EXPECTED_ID;
                        end else begin
                            state_q <= DONE;
                            addr_q  <= 1'b0;
                            rd_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ts_q    <= avm_readdata;
                            tsm_q   <= avm_readdata != EXPECTED_TIMESTAMP;
                            pass_q  <= !(idm_q || (avm_readdata != EXPECTED_TIMESTAMP));
                        end
                    end
`ifdef SYSID_CHECKER_TIMEOUT_EN
                    else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= DONE;
                        addr_q  <= 1'b0;
                        rd_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        to_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_palt_nios_sysid_checker.sv
// tb_palt_nios_sysid_checker: directed and random checks against a transaction-level model.
module tb_palt_nios_sysid_checker;
    localparam logic [31:0] EID = 32'd8;
    localparam logic [31:0] ETS = 32'd1649580841;
    localparam int TO = 16;
`ifdef SYSID_CHECKER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic avm_address, avm_read, busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] read_id, read_ts;

    int checks = 0, errors = 0;
    logic [31:0] id_val = EID, ts_val = ETS;
    int wmode = 0, st = 0;

    palt_nios_sysid_checker #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .pass(pass), .id_mismatch(id_mismatch),
        .ts_mismatch(ts_mismatch), .timeout(timeout), .read_id(read_id), .read_ts(read_ts)
    );

    always #5 clock = ~clock;

    // model: a check is either pending (arm), active on word m_word, or finished
    bit m_arm = 1'b1, m_act = 1'b0, m_word = 1'b0;
    bit m_done = 1'b0, m_pass = 1'b0, m_idm = 1'b0, m_tsm = 1'b0, m_to = 1'b0;
    logic [31:0] m_id = '0, m_ts = '0;
    int m_st = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_arm = 1'b1; m_act = 1'b0; m_word = 1'b0; m_st = 0;
            {m_done, m_pass, m_idm, m_tsm, m_to} = '0;
            m_id = '0; m_ts = '0;
        end else if (m_arm) begin
            m_arm = 1'b0; m_act = 1'b1; m_word = 1'b0; m_st = 0;
        end else if (m_act) begin
            if (!avm_waitrequest) begin
                m_st = 0;
                if (!m_word) begin
                    m_id = avm_readdata; m_idm = (avm_readdata != EID); m_word = 1'b1;
                end else begin
                    m_ts = avm_readdata; m_tsm = (avm_readdata != ETS);
                    m_done = 1'b1; m_pass = !(m_idm || m_tsm); m_act = 1'b0; m_word = 1'b0;
                end
            end else begin
                m_st++;
                if (TO_EN && m_st == TO) begin
                    m_to = 1'b1; m_done = 1'b1; m_pass = 1'b0; m_act = 1'b0; m_word = 1'b0;
                end
            end
        end else if (start) begin
            {m_done, m_pass, m_idm, m_tsm, m_to} = '0;
            m_id = '0; m_ts = '0;
            m_act = 1'b1; m_word = 1'b0; m_st = 0;
        end
    end

    task automatic ck(input string n, input logic [63:0] g, input logic [63:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, g, e, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
        ck("ctl", {avm_read, avm_address, busy}, {m_act, m_act & m_word, m_act});
        ck("flags", {done, pass, id_mismatch, ts_mismatch, timeout}, {m_done, m_pass, m_idm, m_tsm, m_to});
        ck("read_id", read_id, m_id);
        ck("read_ts", read_ts, m_ts);
        case (wmode)
            1: begin
                avm_waitrequest = avm_read && st < 4;
                if (avm_read) st = avm_waitrequest ? st + 1 : 0;
            end
            2: avm_waitrequest = 1'b1;
            3: avm_waitrequest = ($urandom % 3 == 0);
            4: avm_waitrequest = avm_read && avm_address;
            default: avm_waitrequest = 1'b0;
        endcase
        avm_readdata = avm_address ? ts_val : id_val;
    endtask

    initial begin
        repeat (3) cyc();
        ck("rst_outputs", {avm_read, avm_address, busy, done, pass, id_mismatch, ts_mismatch, timeout, read_id, read_ts}, 72'd0);
        reset_n = 1'b1;
        cyc(); cyc();
        ck("auto_e2_done", done, 1'b0);
        cyc();
        ck("auto_done", {done, pass, id_mismatch, ts_mismatch}, 4'b1100);
        ck("auto_id", read_id, 32'd8);
        ck("auto_ts", read_ts, 32'd1649580841);

        id_val = 32'd9;
        start = 1'b1; cyc(); start = 1'b0;
        ck("clr_done", done, 1'b0);
        cyc(); cyc();
        ck("bad_id_flags", {done, pass, id_mismatch, ts_mismatch}, 4'b1010);
        ck("bad_id_val", read_id, 32'd9);
        id_val = EID;

        wmode = 1; st = 0;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (9) cyc();
        ck("ws_e10_done", done, 1'b0);
        cyc();
        ck("ws_e11_done", {done, pass}, 2'b11);

        wmode = 0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        start = 1'b1; cyc(); start = 1'b0;
        ck("ign_done", {done, pass, busy}, 3'b110);
        start = 1'b1; cyc(); start = 1'b0;
        ck("restart_clr", {done, busy}, 2'b01);
        cyc(); cyc();
        ck("restart_done", {done, pass}, 2'b11);

        wmode = 4;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        ck("stall_ts", {avm_read, avm_address}, 2'b11);
        #2 reset_n = 1'b0;
        #1 ck("async_rst", {avm_read, avm_address, busy, done}, 4'b0000);
        wmode = 0;
        cyc(); reset_n = 1'b1;
        cyc(); cyc(); cyc();
        ck("post_rst_done", {done, pass}, 2'b11);

        wmode = 2;
        start = 1'b1; cyc(); start = 1'b0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
        repeat (15) cyc();
        ck("to_e16", {done, timeout}, 2'b00);
        cyc();
        ck("to_hit", {done, pass, id_mismatch, ts_mismatch, timeout, busy, avm_read}, 7'b1000100);
`else
        repeat (40) cyc();
        ck("stuck_busy", {busy, timeout, done, avm_address}, 4'b1000);
`endif
        reset_n = 1'b0; wmode = 0;
        cyc(); reset_n = 1'b1;

        wmode = 3;
        repeat (3000) begin
            cyc();
            start = ($urandom % 6 == 0);
            id_val = ($urandom % 4 == 0) ? $urandom : EID;
            ts_val = ($urandom % 4 == 0) ? $urandom : ETS;
            reset_n = ($urandom % 200 != 0);
        end
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
